divider: RTL

- Multicycle radix-2 restoring divider for the RV32M DIV/DIVU/REM/REMU instructions.
- Companion of the combinational Multiplier in the execute stage: the multiplier forms products, this block undoes them.
- The control FSM holds the instruction in EX while `busy` is high and consumes `result` on the `done` pulse.
- Follows RISC-V divide-by-zero and signed-overflow semantics exactly; never traps.

---
 rtl/divider_if.sv | 12 +
 rtl/divider.sv | 91 +++++++++
 2 files changed

// File: rtl/divider_if.sv
// divider_if: start/operand/result bundle between the execute-stage control and the divider
interface divider_if #(parameter int WIDTH = 32);
   logic             enable;
   logic [WIDTH-1:0] operand_1;
   logic [WIDTH-1:0] operand_2;
   logic [1:0]       op;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] result;
   modport master (output enable, operand_1, operand_2, op, input busy, done, result);
   modport slave (input enable, operand_1, operand_2, op, output busy, done, result);
endinterface

// File: rtl/divider.sv
// divider: multicycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU
module divider #(
   parameter int WIDTH = 32,
   parameter int CNT_W = 6
) (
   input logic      clk,
   input logic      rst,
   divider_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
   state_t           r_state, w_next;
   logic [CNT_W-1:0] r_cnt;
   logic [WIDTH-1:0] r_rem, r_quo, r_dvs, r_result;
   logic             r_op_rem, r_neg_q, r_neg_r;
   logic             w_signed, w_sd, w_ss, w_div0, w_ovf, w_special, w_start, w_last, w_busy, w_done;
   logic [WIDTH-1:0] w_dvd_abs, w_dvs_abs, w_q_fix, w_r_fix;
   logic [WIDTH:0]   w_trial;
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

   assign w_signed  = ~bus.op[0];
   assign w_sd      = w_signed & bus.operand_1[WIDTH-1];
   assign w_ss      = w_signed & bus.operand_2[WIDTH-1];
   assign w_dvd_abs = w_sd ? -bus.operand_1 : bus.operand_1;
   assign w_dvs_abs = w_ss ? -bus.operand_2 : bus.operand_2;
   assign w_div0    = bus.operand_2 == '0;
   assign w_ovf     = w_signed && bus.operand_1 == MIN_NEG && bus.operand_2 == '1;
   assign w_special = w_div0 | w_ovf;
   assign w_start   = r_state == IDLE && bus.enable;
   assign w_last    = r_cnt == CNT_W'(WIDTH - 1);
   // the shifted-in dividend bit joins the partial remainder; bit WIDTH is the trial sign
   assign w_trial   = {r_rem, r_quo[WIDTH-1]} - {1'b0, r_dvs};
   assign w_q_fix   = r_neg_q ? -r_quo : r_quo;
   assign w_r_fix   = r_neg_r ? -r_rem : r_rem;
   assign bus.busy   = w_busy;
   assign bus.done   = w_done;
   assign bus.result = r_result;

   // state register
   always_ff @(posedge clk)
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;

   // next state; special cases skip CALC but still pass through FIX to register the result
   always_comb begin
      w_next = r_state;
      w_busy = 1'b0;
      w_done = 1'b0;
      case (r_state)
         IDLE: w_next = bus.enable ? (w_special ? FIX : CALC) : IDLE;
         CALC: begin
            w_busy = 1'b1;
            w_next = w_last ? FIX : CALC;
         end
         FIX: begin
            w_busy = 1'b1;
            w_next = DONE;
         end
         DONE: begin
            w_done = 1'b1;
            w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   // datapath: latch magnitudes on start, one restoring step per CALC cycle, sign fix into result
   always_ff @(posedge clk)
      if (rst) begin
         r_cnt    <= '0;
         r_rem    <= '0;
         r_quo    <= '0;
         r_dvs    <= '0;
         r_result <= '0;
         r_op_rem <= 1'b0;
         r_neg_q  <= 1'b0;
         r_neg_r  <= 1'b0;
      end else if (w_start) begin
         r_cnt    <= '0;
         r_op_rem <= bus.op[1];
         r_dvs    <= w_dvs_abs;
         r_rem    <= w_div0 ? bus.operand_1 : '0;
         r_quo    <= w_div0 ? '1 : w_ovf ? MIN_NEG : w_dvd_abs;
         r_neg_q  <= ~w_special & (w_sd ^ w_ss);
         r_neg_r  <= ~w_special & w_sd;
      end else if (r_state == CALC) begin
         r_cnt <= r_cnt + 1'b1;
         r_rem <= w_trial[WIDTH] ? {r_rem[WIDTH-2:0], r_quo[WIDTH-1]} : w_trial[WIDTH-1:0];
         r_quo <= {r_quo[WIDTH-2:0], ~w_trial[WIDTH]};
      end else if (r_state == FIX)
         r_result <= r_op_rem ? w_r_fix : w_q_fix;
endmodule
